mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the five-stage pipeline. It sits between the execute stage and write-back. It accepts one instruction per handshake from execute and waits for the data-SRAM `data_ok` of any load or store that execute issued. It aligns and extends load data, selects the multiplier half, and buffers returned data while write-back stalls. After a flush it discards the responses of cancelled requests, and it forwards its destination register and result to decode for bypass and interlock.

## Interface
- Parameters: none. Field widths are fixed by the pipeline buses.

Clock and reset:
- `clk`  in  1  single pipeline clock
- `reset`  in  1  asynchronous, active-high reset

Execute handshake:
- `ex_to_mem_valid`  in  1  execute holds a valid instruction for this stage
- `mem_allowin`  out  1  this stage accepts an instruction this cycle

Execute payload (captured on handshake):
- `ex_pc`  in  32  instruction PC
- `ex_rf_we`  in  1  register-file write enable
- `ex_rf_waddr`  in  5  destination register
- `ex_result`  in  32  ALU/div/counter result; also the memory address
- `ex_ld_op`  in  5  one-hot load type {b, bu, h, hu, w}; 0 = not a load
- `ex_mem_wait`  in  1  execute had an SRAM request accepted for this instruction
- `ex_res_from_mul`  in  1  result comes from the multiplier
- `ex_mul_h`  in  1  select the high word of the product
- `ex_excp`  in  1  instruction carries an exception or ertn

Datapath inputs:
- `mul_result`  in  64  product, valid in the cycle after the instruction leaves execute
- `data_sram_data_ok`  in  1  SRAM response strobe; responses return in request order
- `data_sram_rdata`  in  32  SRAM read data

Flush and exception:
- `mem_flush`  in  1  exception or ertn taken at write-back; kill this stage
- `mem_to_ex_excep`  out  1  `mem_valid & mem_excp`; execute suppresses new SRAM requests

Write-back handshake and payload:
- `wb_allowin`  in  1  write-back accepts an instruction
- `mem_to_wb_valid`  out  1  valid instruction for write-back
- `mem_pc`  out  32  registered PC
- `mem_rf_we`  out  1  registered register-file write enable
- `mem_rf_waddr`  out  5  registered destination register
- `mem_final_result`  out  32  load data, product half, or `ex_result`
- `mem_excp_out`  out  1  registered `ex_excp`

Forwarding:
- `mem_rf_zip`  out  39  {`mem_blocked`, `mem_rf_we & mem_valid`, `mem_rf_waddr`, `mem_final_result`}

## Operation
State registers:
- `mem_valid`: stage holds an instruction.
- `wait_data`: the held instruction's SRAM response is still due.
- `buf_valid` and `rdata_buf[31:0]`: response already received and held.
- `cancel_cnt[1:0]`: number of orphaned responses still to be discarded.

Per-instruction sub-states:
- EMPTY (`mem_valid` = 0).
- WAIT (`wait_data` = 1).
- READY (`wait_data` = 0, or `buf_valid` = 1, or own `data_ok` this cycle).

Ownership of a response:
- A response belongs to the held instruction when `data_sram_data_ok & cancel_cnt == 0`.
- If `cancel_cnt != 0`, the response decrements `cancel_cnt` and is dropped.

Control equations:
- `ready_go` = `~wait_data | buf_valid | own_ok`.
- `mem_allowin` = `(~mem_valid | ready_go & wb_allowin | mem_flush) & (cancel_cnt != 3)`.
- On handshake: payload registers load; `wait_data` <= `ex_mem_wait`; `buf_valid` <= 0.
- `own_ok` while `wb_allowin` = 0: `rdata_buf` <= `data_sram_rdata`, `buf_valid` <= 1, `wait_data` <= 0.

Flush:
- `mem_valid` <= 0 (execute is flushed in the same cycle, so no handshake occurs).
- If the held instruction is in WAIT and no own response arrives this cycle, `cancel_cnt` increments.
- A simultaneous orphan response also decrements `cancel_cnt`; net change 0.

Load extraction (data = `buf_valid ? rdata_buf : data_sram_rdata`, offset = `ex_result[1:0]` as registered):
- b / bu: byte at offset×8, sign- or zero-extended to 32 bits.
- h / hu: halfword at offset[1]×16, sign- or zero-extended to 32 bits.
- w: the full word.

Result priority:
- Any load: loaded data.
- Else `ex_res_from_mul`: `mul_h ? mul_result[63:32] : mul_result[31:0]`.
- Else: `ex_result`.

Interlock output:
- `mem_blocked` = `mem_valid & |ld_op & ~ready_go`; decode stalls on it.

## Timing
- Reset values: `mem_valid`, `wait_data`, `buf_valid`, `cancel_cnt` and all payload registers are 0. Every output reads 0 after reset, except `mem_allowin` = 1.
- `mem_to_wb_valid` = `mem_valid & ready_go & ~mem_flush`.
- Latency:
  - 1 cycle for non-memory instructions.
  - For loads and stores, `mem_to_wb_valid` rises combinationally in the cycle `data_ok` arrives. No extra cycle is added.
- A buffered response survives any number of `wb_allowin` = 0 cycles. `rdata_buf` is never overwritten while `buf_valid` = 1.
- Reset asserted mid-WAIT clears everything asynchronously, including `cancel_cnt`. Pending responses after reset are the SRAM's responsibility.
- A store completes like a load but its result is `ex_result`; `mem_rf_we` from execute is 0 for stores.

## Test plan
1. ALU op: `ex_result`=0x1234, we=1, rd=5, `wb_allowin`=1 -> next cycle `mem_to_wb_valid`=1, `mem_final_result`=0x1234, zip={0,1,5,0x1234}.
2. ld.b at addr 0x...3 (`ex_mem_wait`=1), `data_ok` 3 cycles later, rdata=0x80FF_0000 -> `mem_blocked`=1 for 2 cycles, then result 0xFFFF_FF80; with ld.bu the result is 0x0000_0080.
3. ld.h at addr 0x...2, `data_ok` arrives while `wb_allowin`=0 for 4 cycles, rdata=0x7FFE_1234 -> buffered; result 0x0000_7FFE when `wb_allowin` rises; no SRAM input change affects it.
4. Flush during WAIT, then a new ld.w issued, then two `data_ok` (0xDEAD, 0xBEEF) -> first dropped (`cancel_cnt` 1->0), the new load retires with 0xBEEF.
5. mul with `mul_h`=1, product 0x0000_0002_0000_0003 -> result 0x2; with `mul_h`=0 -> 0x3.
6. `ex_excp`=1 instruction held -> `mem_to_ex_excep`=1; `mem_flush` same cycle as `wb_allowin`=1 -> `mem_to_wb_valid`=0, `mem_valid`=0 next cycle.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the five-stage pipeline.
//
// Holds one instruction between execute and write-back. For an instruction
// whose SRAM request was accepted in execute, the stage waits for the
// matching data_ok. If write-back is stalled when data_ok arrives, the read
// data is buffered. Load data is aligned and extended here, and the
// multiplier half is selected here. After a flush, the responses of
// cancelled requests are counted and dropped. The destination register and
// the result are forwarded to decode for bypass and load-use interlock.
//
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   ex_to_mem_valid / mem_allowin execute -> mem handshake
//   ex_*                          execute payload, captured on handshake
//   mul_result                    64-bit product, valid while instr is here
//   data_sram_data_ok/_rdata      in-order SRAM response channel
//   mem_flush                     kill this stage (exception/ertn at WB)
//   mem_to_ex_excep               held instr carries an exception
//   wb_allowin / mem_to_wb_valid  mem -> write-back handshake
//   mem_pc .. mem_excp_out        write-back payload
//   mem_rf_zip                    {blocked, we&valid, waddr, result} to decode
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_to_mem_valid,
    output logic        mem_allowin,
    input  logic [31:0] ex_pc,
    input  logic        ex_rf_we,
    input  logic [4:0]  ex_rf_waddr,
    input  logic [31:0] ex_result,
    input  logic [4:0]  ex_ld_op,
    input  logic        ex_mem_wait,
    input  logic        ex_res_from_mul,
    input  logic        ex_mul_h,
    input  logic        ex_excp,
    input  logic [63:0] mul_result,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    input  logic        mem_flush,
    output logic        mem_to_ex_excep,
    input  logic        wb_allowin,
    output logic        mem_to_wb_valid,
    output logic [31:0] mem_pc,
    output logic        mem_rf_we,
    output logic [4:0]  mem_rf_waddr,
    output logic [31:0] mem_final_result,
    output logic        mem_excp_out,
    output logic [38:0] mem_rf_zip
);

    logic        mem_valid_r;
    logic        wait_data_r;
    logic        buf_valid_r;
    logic [31:0] rdata_buf_r;
    logic [1:0]  cancel_cnt_r;

    logic [31:0] pc_r;
    logic        rf_we_r;
    logic [4:0]  rf_waddr_r;
    logic [31:0] result_r;
    logic [4:0]  ld_op_r;
    logic        res_from_mul_r;
    logic        mul_h_r;
    logic        excp_r;

    logic        cancel_zero_s;
    logic        own_ok_s;
    logic        orphan_ok_s;
    logic        ready_go_s;
    logic        cancel_inc_s;
    logic        blocked_s;
    logic [31:0] ld_data_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic [31:0] load_val_s;
    logic [31:0] final_s;

    assign cancel_zero_s = (cancel_cnt_r == 2'd0);
    // Responses come back in order, so while orphans are outstanding the next
    // data_ok can never belong to the held instruction.
    assign own_ok_s      = data_sram_data_ok & cancel_zero_s & mem_valid_r & wait_data_r;
    assign orphan_ok_s   = data_sram_data_ok & ~cancel_zero_s;
    assign ready_go_s    = ~wait_data_r | buf_valid_r | own_ok_s;
    // A full orphan counter stalls intake so the count cannot wrap.
    assign mem_allowin   = (~mem_valid_r | (ready_go_s & wb_allowin) | mem_flush)
                           & (cancel_cnt_r != 2'd3);
    // A flushed instruction whose response is still due leaves one orphan.
    assign cancel_inc_s  = mem_flush & mem_valid_r & wait_data_r & ~own_ok_s;
    assign blocked_s     = mem_valid_r & (|ld_op_r) & ~ready_go_s;

    // Stage occupancy, response wait/buffer state and payload capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_valid_r    <= 1'b0;
            wait_data_r    <= 1'b0;
            buf_valid_r    <= 1'b0;
            rdata_buf_r    <= 32'h0;
            pc_r           <= 32'h0;
            rf_we_r        <= 1'b0;
            rf_waddr_r     <= 5'd0;
            result_r       <= 32'h0;
            ld_op_r        <= 5'd0;
            res_from_mul_r <= 1'b0;
            mul_h_r        <= 1'b0;
            excp_r         <= 1'b0;
        end else if (mem_flush) begin
            mem_valid_r <= 1'b0;
            wait_data_r <= 1'b0;
            buf_valid_r <= 1'b0;
        end else if (mem_allowin) begin
            mem_valid_r <= ex_to_mem_valid;
            buf_valid_r <= 1'b0;
            if (ex_to_mem_valid) begin
                wait_data_r    <= ex_mem_wait;
                pc_r           <= ex_pc;
                rf_we_r        <= ex_rf_we;
                rf_waddr_r     <= ex_rf_waddr;
                result_r       <= ex_result;
                ld_op_r        <= ex_ld_op;
                res_from_mul_r <= ex_res_from_mul;
                mul_h_r        <= ex_mul_h;
                excp_r         <= ex_excp;
            end else begin
                wait_data_r <= 1'b0;
            end
        end else if (own_ok_s) begin
            // Not allowed in while own_ok is set means write-back is stalled.
            // wait_data clears here, so the buffer is written only once.
            wait_data_r <= 1'b0;
            buf_valid_r <= 1'b1;
            rdata_buf_r <= data_sram_rdata;
        end else begin
            mem_valid_r <= mem_valid_r;
        end
    end

    // Orphaned-response counter: flush of a waiting instr adds, orphan data_ok drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cancel_cnt_r <= 2'd0;
        end else begin
            case ({cancel_inc_s, orphan_ok_s})
                2'b10:   cancel_cnt_r <= cancel_cnt_r + 2'd1;
                2'b01:   cancel_cnt_r <= cancel_cnt_r - 2'd1;
                default: cancel_cnt_r <= cancel_cnt_r;
            endcase
        end
    end

    // Load alignment and extension from the buffered or live read data.
    always_comb begin
        ld_data_s = buf_valid_r ? rdata_buf_r : data_sram_rdata;
        case (result_r[1:0])
            2'd0:    byte_s = ld_data_s[7:0];
            2'd1:    byte_s = ld_data_s[15:8];
            2'd2:    byte_s = ld_data_s[23:16];
            default: byte_s = ld_data_s[31:24];
        endcase
        half_s = result_r[1] ? ld_data_s[31:16] : ld_data_s[15:0];
        case (ld_op_r)
            5'b10000: load_val_s = {{24{byte_s[7]}}, byte_s};
            5'b01000: load_val_s = {24'h0, byte_s};
            5'b00100: load_val_s = {{16{half_s[15]}}, half_s};
            5'b00010: load_val_s = {16'h0, half_s};
            5'b00001: load_val_s = ld_data_s;
            default:  load_val_s = 32'h0;
        endcase
    end

    // Result select: load data, then multiplier half, then execute result.
    always_comb begin
        if (|ld_op_r) begin
            final_s = load_val_s;
        end else if (res_from_mul_r) begin
            final_s = mul_h_r ? mul_result[63:32] : mul_result[31:0];
        end else begin
            final_s = result_r;
        end
    end

    assign mem_to_wb_valid  = mem_valid_r & ready_go_s & ~mem_flush;
    assign mem_to_ex_excep  = mem_valid_r & excp_r;
    assign mem_pc           = pc_r;
    assign mem_rf_we        = rf_we_r;
    assign mem_rf_waddr     = rf_waddr_r;
    assign mem_excp_out     = excp_r;
    assign mem_final_result = final_s;
    assign mem_rf_zip       = {blocked_s, rf_we_r & mem_valid_r, rf_waddr_r, final_s};

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: per-cycle directed vector table plus a few
// hand-written sequences (payload capture, orphan counter saturation,
// asynchronous reset during a wait).
module tb_mem_stage;

    logic        clk;
    logic        reset;
    logic        ex_to_mem_valid;
    logic        mem_allowin;
    logic [31:0] ex_pc;
    logic        ex_rf_we;
    logic [4:0]  ex_rf_waddr;
    logic [31:0] ex_result;
    logic [4:0]  ex_ld_op;
    logic        ex_mem_wait;
    logic        ex_res_from_mul;
    logic        ex_mul_h;
    logic        ex_excp;
    logic [63:0] mul_result;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        mem_flush;
    logic        mem_to_ex_excep;
    logic        wb_allowin;
    logic        mem_to_wb_valid;
    logic [31:0] mem_pc;
    logic        mem_rf_we;
    logic [4:0]  mem_rf_waddr;
    logic [31:0] mem_final_result;
    logic        mem_excp_out;
    logic [38:0] mem_rf_zip;

    int checks = 0;
    int errors = 0;

    mem_stage dut (
        .clk(clk), .reset(reset),
        .ex_to_mem_valid(ex_to_mem_valid), .mem_allowin(mem_allowin),
        .ex_pc(ex_pc), .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr),
        .ex_result(ex_result), .ex_ld_op(ex_ld_op), .ex_mem_wait(ex_mem_wait),
        .ex_res_from_mul(ex_res_from_mul), .ex_mul_h(ex_mul_h), .ex_excp(ex_excp),
        .mul_result(mul_result),
        .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
        .mem_flush(mem_flush), .mem_to_ex_excep(mem_to_ex_excep),
        .wb_allowin(wb_allowin), .mem_to_wb_valid(mem_to_wb_valid),
        .mem_pc(mem_pc), .mem_rf_we(mem_rf_we), .mem_rf_waddr(mem_rf_waddr),
        .mem_final_result(mem_final_result), .mem_excp_out(mem_excp_out),
        .mem_rf_zip(mem_rf_zip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] res;
        logic        we;
        logic [4:0]  rd;
        logic [4:0]  ld;
        logic        mw;
        logic        mul;
        logic        mh;
        logic        excp;
        logic        ok;
        logic [31:0] rdata;
        logic        fl;
        logic        wba;
        logic        e_allow;
        logic        e_wbv;
        logic        e_exc;
        logic [38:0] e_zip;
    } vec_t;

    vec_t vec[$];

    function automatic logic [38:0] z(input logic b, input logic w, input logic [4:0] a,
                                      input logic [31:0] r);
        return {b, w, a, r};
    endfunction

    function automatic vec_t mk(input logic v, input logic [31:0] res, input logic we,
                                input logic [4:0] rd, input logic [4:0] ld, input logic mw,
                                input logic mul, input logic mh, input logic excp,
                                input logic ok, input logic [31:0] rdata, input logic fl,
                                input logic wba, input logic e_allow, input logic e_wbv,
                                input logic e_exc, input logic [38:0] e_zip);
        vec_t t;
        t.v = v; t.res = res; t.we = we; t.rd = rd; t.ld = ld; t.mw = mw;
        t.mul = mul; t.mh = mh; t.excp = excp; t.ok = ok; t.rdata = rdata;
        t.fl = fl; t.wba = wba; t.e_allow = e_allow; t.e_wbv = e_wbv;
        t.e_exc = e_exc; t.e_zip = e_zip;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        ex_to_mem_valid   = 1'b0;
        ex_pc             = 32'h0;
        ex_rf_we          = 1'b0;
        ex_rf_waddr       = 5'd0;
        ex_result         = 32'h0;
        ex_ld_op          = 5'd0;
        ex_mem_wait       = 1'b0;
        ex_res_from_mul   = 1'b0;
        ex_mul_h          = 1'b0;
        ex_excp           = 1'b0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;
        mem_flush         = 1'b0;
        wb_allowin        = 1'b1;
    endtask

    task automatic apply(input vec_t t);
        ex_to_mem_valid   = t.v;
        ex_result         = t.res;
        ex_rf_we          = t.we;
        ex_rf_waddr       = t.rd;
        ex_ld_op          = t.ld;
        ex_mem_wait       = t.mw;
        ex_res_from_mul   = t.mul;
        ex_mul_h          = t.mh;
        ex_excp           = t.excp;
        data_sram_data_ok = t.ok;
        data_sram_rdata   = t.rdata;
        mem_flush         = t.fl;
        wb_allowin        = t.wba;
    endtask

    task automatic issue_ld_w(input logic [31:0] addr, input logic [4:0] rd);
        idle();
        ex_to_mem_valid = 1'b1;
        ex_result       = addr;
        ex_ld_op        = 5'b00001;
        ex_mem_wait     = 1'b1;
        ex_rf_we        = 1'b1;
        ex_rf_waddr     = rd;
    endtask

    initial begin
        // v, res, we, rd, ld, mw, mul, mh, excp, ok, rdata, fl, wba | allow, wbv, exc, zip
        // ALU op
        vec.push_back(mk(1'b1, 32'h1234, 1'b1, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, z(1'b0, 1'b0, 5'd0, 32'h0)));
        vec.push_back(mk(1'b0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, z(1'b0, 1'b1, 5'd5, 32'h1234)));
        // ld.b @..3, data_ok three cycles after issue
        vec.push_back(mk(1'b1, 32'h1003, 1'b1, 5'd7, 5'b10000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, z(1'b0, 1'b0, 5'd5, 32'h1234)));
        vec.push_back(mk(1'b0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, z(1'b1, 1'b1, 5'd7, 32'h0)));
        vec.push_back(mk(1'b0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, z(1'b1, 1'b1, 5'd7, 32'h0)));
        // data_ok for ld.b; ld.bu enters in the same cycle
        vec.push_back(mk(1'b1, 32'h1003, 1'b1, 5'd8, 5'b01000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h80FF_0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, z(1'b0, 1'b1, 5'd7, 32'hFFFF_FF80)));
        vec.push_back(mk(1'b0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, z(1'b1, 1'b1, 5'd8, 32'h0)));
        vec.push_back(mk(1'b0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h80FF_0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, z(1'b0, 1'b1, 5'd8, 32'h0000_0080)));
        // ld.h @..2, response buffered across four wb stall cycles
        vec.push_back(mk(1'b1, 32'h2002, 1'b1, 5'd9, 5'b00100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, z(1'b0, 1'b0, 5'd8, 32'h0)));
        vec.push_back(mk(1'b0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h7FFE_1234, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, z(1'b0, 1'b1, 5'd9, 32'h0000_7FFE)));
        for (int i = 0; i < 3; i++)
            vec.push_back(mk(1'b0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, z(1'b0, 1'b1, 5'd9, 32'h0000_7FFE)));
        vec.push_back(mk(1'b0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, z(1'b0, 1'b1, 5'd9, 32'h0000_7FFE)));
        // mul high then mul low, product 0x0000_0002_0000_0003
        vec.push_back(mk(1'b1, 32'h99, 1'b1, 5'd10, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, z(1'b0, 1'b0, 5'd9, 32'h0)));
        vec.push_back(mk(1'b1, 32'h77, 1'b1, 5'd11, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, z(1'b0, 1'b1, 5'd10, 32'h2)));
        vec.push_back(mk(1'b0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, z(1'b0, 1'b1, 5'd11, 32'h3)));
        // exception instruction, then flush while wb accepts
        vec.push_back(mk(1'b1, 32'h55, 1'b0, 5'd12, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, z(1'b0, 1'b0, 5'd11, 32'h3)));
        vec.push_back(mk(1'b0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, z(1'b0, 1'b0, 5'd12, 32'h55)));
        vec.push_back(mk(1'b0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, z(1'b0, 1'b0, 5'd12, 32'h55)));
        vec.push_back(mk(1'b0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, z(1'b0, 1'b0, 5'd12, 32'h55)));
        // ld.w flushed in WAIT, new ld.w, orphan 0xDEAD dropped, own 0xBEEF kept
        vec.push_back(mk(1'b1, 32'h3000, 1'b1, 5'd13, 5'b00001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, z(1'b0, 1'b0, 5'd12, 32'h55)));
        vec.push_back(mk(1'b0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, z(1'b1, 1'b1, 5'd13, 32'h0)));
        vec.push_back(mk(1'b0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, z(1'b1, 1'b1, 5'd13, 32'h0)));
        vec.push_back(mk(1'b1, 32'h3004, 1'b1, 5'd14, 5'b00001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, z(1'b0, 1'b0, 5'd13, 32'h0)));
        vec.push_back(mk(1'b0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, z(1'b1, 1'b1, 5'd14, 32'hDEAD)));
        vec.push_back(mk(1'b0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hBEEF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, z(1'b0, 1'b1, 5'd14, 32'hBEEF)));
        vec.push_back(mk(1'b0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, z(1'b0, 1'b0, 5'd14, 32'h0)));

        // Reset state
        reset      = 1'b1;
        mul_result = 64'h0000_0002_0000_0003;
        idle();
        #1;
        chk("rst_allowin", {63'h0, mem_allowin}, 64'h1);
        chk("rst_wbv", {63'h0, mem_to_wb_valid}, 64'h0);
        chk("rst_zip", {25'h0, mem_rf_zip}, 64'h0);
        chk("rst_pc", {32'h0, mem_pc}, 64'h0);
        chk("rst_misc", {60'h0, mem_rf_we, mem_excp_out, mem_to_ex_excep, 1'b0}, 64'h0);
        @(negedge clk);
        reset = 1'b0;

        // Vector table, one row per cycle
        for (int i = 0; i < vec.size(); i++) begin
            @(negedge clk);
            apply(vec[i]);
            #1;
            chk($sformatf("v%0d_allowin", i), {63'h0, mem_allowin}, {63'h0, vec[i].e_allow});
            chk($sformatf("v%0d_wbv", i), {63'h0, mem_to_wb_valid}, {63'h0, vec[i].e_wbv});
            chk($sformatf("v%0d_excep", i), {63'h0, mem_to_ex_excep}, {63'h0, vec[i].e_exc});
            chk($sformatf("v%0d_zip", i), {25'h0, mem_rf_zip}, {25'h0, vec[i].e_zip});
        end

        // Payload registers
        @(negedge clk);
        idle();
        ex_to_mem_valid = 1'b1;
        ex_pc           = 32'h1C00_0040;
        ex_rf_we        = 1'b1;
        ex_rf_waddr     = 5'd3;
        ex_result       = 32'hA;
        ex_excp         = 1'b1;
        @(negedge clk);
        idle();
        #1;
        chk("pl_pc", {32'h0, mem_pc}, {32'h0, 32'h1C00_0040});
        chk("pl_we_waddr", {58'h0, mem_rf_we, mem_rf_waddr}, {58'h0, 1'b1, 5'd3});
        chk("pl_excp", {62'h0, mem_excp_out, mem_to_ex_excep}, {62'h0, 2'b11});
        chk("pl_result", {32'h0, mem_final_result}, {32'h0, 32'hA});

        // Three flushed waiting loads saturate the orphan counter
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            issue_ld_w(32'h4000, 5'd15);
            @(negedge clk);
            idle();
            mem_flush = 1'b1;
        end
        @(negedge clk);
        idle();
        #1;
        chk("cnt3_allowin", {63'h0, mem_allowin}, 64'h0);
        data_sram_data_ok = 1'b1;
        #1;
        chk("cnt3_ok_allowin", {63'h0, mem_allowin}, 64'h0);
        @(negedge clk);
        #1;
        chk("cnt2_allowin", {63'h0, mem_allowin}, 64'h1);
        @(negedge clk);
        data_sram_data_ok = 1'b1;
        @(negedge clk);
        issue_ld_w(32'h4008, 5'd16);
        @(negedge clk);
        idle();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h1234_5678;
        #1;
        chk("drained_wbv", {63'h0, mem_to_wb_valid}, 64'h1);
        chk("drained_result", {32'h0, mem_final_result}, {32'h0, 32'h1234_5678});

        // Asynchronous reset in the middle of a wait
        @(negedge clk);
        issue_ld_w(32'h5000, 5'd17);
        ex_pc = 32'h1C00_0080;
        @(negedge clk);
        idle();
        #1;
        chk("pre_rst_blocked", {63'h0, mem_rf_zip[38]}, 64'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_zip", {25'h0, mem_rf_zip}, 64'h0);
        chk("async_rst_allowin", {63'h0, mem_allowin}, 64'h1);
        chk("async_rst_pc", {32'h0, mem_pc}, 64'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_wbv", {63'h0, mem_to_wb_valid}, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
